// File: rtl/lo_pkg.sv
// Shared LO definitions for the fs/4 down-mixer (lo_demod) and the up-mixer.
// Contents:
//   SAMPLE_W      sample width of the mixer datapath
//   TERM_W        width of one product term (one extra bit so that negating
//                 the most negative sample is exact)
//   lo_code_t     2-bit LO code, LO_ZERO / LO_POS / LO_NEG (2'b11 unused)
//   lo_apply()    multiply a sample by an LO code (+1, -1 or 0)
package lo_pkg;

    localparam int SAMPLE_W = 20;
    localparam int TERM_W   = SAMPLE_W + 1;

    typedef logic [1:0] lo_code_t;

    localparam lo_code_t LO_ZERO = 2'b00;
    localparam lo_code_t LO_POS  = 2'b01;
    localparam lo_code_t LO_NEG  = 2'b10;

    function automatic logic signed [TERM_W-1:0] lo_apply(
        input lo_code_t                   code,
        input logic signed [SAMPLE_W-1:0] s
    );
        logic signed [TERM_W-1:0] ext;
        ext = {s[SAMPLE_W-1], s};
        case (code)
            LO_POS:  lo_apply = ext;
            LO_NEG:  lo_apply = -ext;
            default: lo_apply = '0;
        endcase
    endfunction

endpackage

// File: rtl/lo_seq.sv
// fs/4 LO sequencer: 2-bit phase counter plus I/Q LO code decode.
// Ports:
//   clk, rst   clock and synchronous active-high reset (phase -> 0)
//   advance    step the phase by one (wraps 3 -> 0)
//   lo_i       I-path LO code for the current phase: +1, 0, -1, 0
//   lo_q       Q-path LO code for the current phase:  0,+1, 0, -1
module lo_seq
    import lo_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     advance,
    output lo_code_t lo_i,
    output lo_code_t lo_q
);

    logic [1:0] phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 2'd0;
        end else if (advance) begin
            phase <= phase + 2'd1;
        end
    end

    always_comb begin
        lo_i = LO_ZERO;
        lo_q = LO_ZERO;
        case (phase)
            2'd0: lo_i = LO_POS;
            2'd1: lo_q = LO_POS;
            2'd2: lo_i = LO_NEG;
            2'd3: lo_q = LO_NEG;
            default: ;
        endcase
    end

endmodule

// File: rtl/lo_demod.sv
// fs/4 quadrature down-converter with integrate-and-dump.
// Each consumed sample is multiplied by the I and Q LO codes and added to
// the I/Q accumulators; every N = 2^LOG2_N samples the sums are scaled by
// 2^-(LOG2_N-1) (floor), presented on i_o/q_o with a valid/ready handshake,
// and the accumulators restart from zero.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en_i          block enable; low holds all sample-path state
//   mix_i         signed mixed input sample, mix_valid_i qualifies it
//   out_ready_i   downstream accepts the current result
//   i_o, q_o      signed baseband result, out_valid_o marks it unconsumed
//   overrun_o     sticky: an unconsumed result was overwritten
//   lo_o          I-path LO code for the current phase (debug)
module lo_demod
    import lo_pkg::*;
#(
    parameter int LOG2_N = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic signed [SAMPLE_W-1:0] mix_i,
    input  logic                       mix_valid_i,
    input  logic                       out_ready_i,
    output logic signed [SAMPLE_W-1:0] i_o,
    output logic signed [SAMPLE_W-1:0] q_o,
    output logic                       out_valid_o,
    output logic                       overrun_o,
    output logic [1:0]                 lo_o
);

    localparam int ACC_W = TERM_W + LOG2_N;

    // Floor scaling of a completed dump. The result is known to fit in
    // SAMPLE_W bits, so the upper bits are simply dropped.
    function automatic logic signed [SAMPLE_W-1:0] dump_scale(
        input logic signed [ACC_W-1:0] v
    );
        logic signed [ACC_W-1:0] sh;
        sh = v >>> (LOG2_N - 1);
        return sh[SAMPLE_W-1:0];
    endfunction

    lo_code_t                  lo_i, lo_q;
    logic                      consume, last, load;
    logic [LOG2_N-1:0]         cnt;
    logic signed [TERM_W-1:0]  term_i, term_q;
    logic signed [ACC_W-1:0]   acc_i, acc_q, sum_i, sum_q;

    assign consume = en_i & mix_valid_i;
    assign last    = &cnt;
    assign load    = consume & last;

    lo_seq u_lo_seq (
        .clk     (clk),
        .rst     (rst),
        .advance (consume),
        .lo_i    (lo_i),
        .lo_q    (lo_q)
    );

    assign lo_o   = lo_i;
    assign term_i = lo_apply(lo_i, mix_i);
    assign term_q = lo_apply(lo_q, mix_i);
    assign sum_i  = acc_i + {{LOG2_N{term_i[TERM_W-1]}}, term_i};
    assign sum_q  = acc_q + {{LOG2_N{term_q[TERM_W-1]}}, term_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            acc_i       <= '0;
            acc_q       <= '0;
            i_o         <= '0;
            q_o         <= '0;
            out_valid_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (consume) begin
                // cnt wraps to zero by itself after N-1
                cnt <= cnt + 1'b1;
                if (last) begin
                    acc_i <= '0;
                    acc_q <= '0;
                    i_o   <= dump_scale(sum_i);
                    q_o   <= dump_scale(sum_q);
                end else begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                end
            end

            if (load) begin
                out_valid_o <= 1'b1;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end

            if (load && out_valid_o && !out_ready_i) begin
                overrun_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lo_demod.sv
module tb_lo_demod;

    localparam int LOG2_N = 6;
    localparam int N      = 1 << LOG2_N;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_i;
    logic [19:0] mix_i;
    logic        mix_valid_i;
    logic        out_ready_i;
    logic [19:0] i_o;
    logic [19:0] q_o;
    logic        out_valid_o;
    logic        overrun_o;
    logic [1:0]  lo_o;

    lo_demod #(.LOG2_N(LOG2_N)) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .mix_i       (mix_i),
        .mix_valid_i (mix_valid_i),
        .out_ready_i (out_ready_i),
        .i_o         (i_o),
        .q_o         (q_o),
        .out_valid_o (out_valid_o),
        .overrun_o   (overrun_o),
        .lo_o        (lo_o)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr    = 0;

    typedef struct {
        string       name;
        logic [19:0] p0, p1, p2, p3;
        logic [19:0] exp_i, exp_q;
    } vec_t;

    vec_t vecs[6];
    logic signed [19:0] dump_buf[N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [19:0] s, input bit en, input bit vld, input bit rdy);
        mix_i       = s;
        en_i        = en;
        mix_valid_i = vld;
        out_ready_i = rdy;
        tick();
    endtask

    task automatic idle(input bit rdy);
        feed(20'h0, 1'b0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1'b0);
        idle(1'b0);
        rst = 1'b0;
    endtask

    function automatic logic [19:0] pat_sel(input vec_t v, input int k);
        case (k % 4)
            0: return v.p0;
            1: return v.p1;
            2: return v.p2;
            default: return v.p3;
        endcase
    endfunction

    // Tone on the I axis: +A, 0, -A, 0
    function automatic logic [19:0] tone_i(input int k);
        case (k % 4)
            0: return 20'h40000;
            2: return 20'hC0000;
            default: return 20'h0;
        endcase
    endfunction

    // Reference: multiply by cos/sin of the fs/4 carrier (1,0,-1,0 / 0,1,0,-1),
    // sum over the dump, divide by N/2 rounding toward minus infinity.
    function automatic logic [19:0] model(input bit q_path);
        longint acc, d, quo;
        logic [63:0] tmp;
        int w;
        acc = 0;
        for (int k = 0; k < N; k++) begin
            if (!q_path) w = (k % 4 == 0) ? 1 : (k % 4 == 2) ? -1 : 0;
            else         w = (k % 4 == 1) ? 1 : (k % 4 == 3) ? -1 : 0;
            acc += longint'(w) * longint'(dump_buf[k]);
        end
        d   = longint'(N / 2);
        quo = acc / d;
        if ((acc % d != 0) && (acc < 0)) quo = quo - 1;
        tmp = quo;
        return tmp[19:0];
    endfunction

    initial begin
        rst = 1'b0;
        en_i = 1'b0;
        mix_valid_i = 1'b0;
        out_ready_i = 1'b0;
        mix_i = '0;

        vecs[0] = '{"tone_i",   20'h40000, 20'h0, 20'hC0000, 20'h0, 20'h40000, 20'h0};
        vecs[1] = '{"tone_q",   20'h0, 20'h40000, 20'h0, 20'hC0000, 20'h0, 20'h40000};
        vecs[2] = '{"tone_qn",  20'h0, 20'hC0000, 20'h0, 20'h40000, 20'h0, 20'hC0000};
        vecs[3] = '{"fs_pos",   20'h7FFFF, 20'h0, 20'h80000, 20'h0, 20'h7FFFF, 20'h0};
        vecs[4] = '{"fs_neg",   20'h80000, 20'h0, 20'h7FFFF, 20'h0, 20'h80000, 20'h0};
        vecs[5] = '{"dc",       20'h12345, 20'h12345, 20'h12345, 20'h12345, 20'h0, 20'h0};

        // Reset state and LO sequencing
        do_reset();
        check("rst_i", {12'h0, i_o}, 32'h0);
        check("rst_q", {12'h0, q_o}, 32'h0);
        check("rst_valid", {31'h0, out_valid_o}, 32'h0);
        check("rst_overrun", {31'h0, overrun_o}, 32'h0);
        check("rst_lo", {30'h0, lo_o}, 32'h1);
        feed(20'h0, 1'b1, 1'b1, 1'b1);
        check("lo_p1", {30'h0, lo_o}, 32'h0);
        feed(20'h0, 1'b0, 1'b1, 1'b1);
        check("lo_hold_en", {30'h0, lo_o}, 32'h0);
        feed(20'h0, 1'b1, 1'b0, 1'b1);
        check("lo_hold_vld", {30'h0, lo_o}, 32'h0);
        feed(20'h0, 1'b1, 1'b1, 1'b1);
        check("lo_p2", {30'h0, lo_o}, 32'h2);

        // Table-driven tone dumps
        foreach (vecs[v]) begin
            do_reset();
            for (int k = 0; k < N; k++) begin
                if (k == N - 1) check({vecs[v].name, "_valid_early"}, {31'h0, out_valid_o}, 32'h0);
                feed(pat_sel(vecs[v], k), 1'b1, 1'b1, 1'b1);
            end
            check({vecs[v].name, "_valid"}, {31'h0, out_valid_o}, 32'h1);
            check({vecs[v].name, "_i"}, {12'h0, i_o}, {12'h0, vecs[v].exp_i});
            check({vecs[v].name, "_q"}, {12'h0, q_o}, {12'h0, vecs[v].exp_q});
            idle(1'b1);
            check({vecs[v].name, "_valid_clr"}, {31'h0, out_valid_o}, 32'h0);
        end

        // Two dumps with no ready: overwrite, sticky overrun, stable output
        do_reset();
        for (int k = 0; k < N; k++) feed(tone_i(k), 1'b1, 1'b1, 1'b0);
        check("ovr_first_valid", {31'h0, out_valid_o}, 32'h1);
        check("ovr_first_flag", {31'h0, overrun_o}, 32'h0);
        for (int k = 0; k < N; k++) begin
            if (k == N / 2) check("ovr_stable_i", {12'h0, i_o}, 32'h40000);
            feed(pat_sel(vecs[1], k), 1'b1, 1'b1, 1'b0);
        end
        check("ovr_second_i", {12'h0, i_o}, 32'h0);
        check("ovr_second_q", {12'h0, q_o}, 32'h40000);
        check("ovr_valid", {31'h0, out_valid_o}, 32'h1);
        check("ovr_flag", {31'h0, overrun_o}, 32'h1);
        idle(1'b1);
        check("ovr_valid_clr", {31'h0, out_valid_o}, 32'h0);
        check("ovr_sticky", {31'h0, overrun_o}, 32'h1);
        do_reset();
        check("ovr_rst_clr", {31'h0, overrun_o}, 32'h0);

        // Ready asserted on the load edge of the second dump: no overrun
        for (int k = 0; k < N; k++) feed(tone_i(k), 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < N; k++) feed(pat_sel(vecs[2], k), 1'b1, 1'b1, (k == N - 1));
        check("rdy_load_valid", {31'h0, out_valid_o}, 32'h1);
        check("rdy_load_flag", {31'h0, overrun_o}, 32'h0);
        check("rdy_load_q", {12'h0, q_o}, 32'hC0000);

        // Reset mid-dump with a pending result
        do_reset();
        for (int k = 0; k < N; k++) feed(tone_i(k), 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 30; k++) feed(20'h7FFFF, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        feed(20'h7FFFF, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        check("mid_rst_valid", {31'h0, out_valid_o}, 32'h0);
        check("mid_rst_i", {12'h0, i_o}, 32'h0);
        check("mid_rst_lo", {30'h0, lo_o}, 32'h1);
        for (int k = 0; k < N; k++) feed(tone_i(k), 1'b1, 1'b1, 1'b1);
        check("mid_rst_clean_i", {12'h0, i_o}, 32'h40000);
        check("mid_rst_clean_q", {12'h0, q_o}, 32'h0);

        // Tone with random enable / valid gaps
        begin
            int got = 0;
            int cyc = 0;
            bit en, vld;
            do_reset();
            while (got < N && cyc < 2000) begin
                en  = ($urandom_range(0, 3) != 0);
                vld = ($urandom_range(0, 3) != 0);
                feed(tone_i(got), en, vld, 1'b0);
                if (en && vld) got++;
                cyc++;
            end
            check("gap_done", got, N);
            check("gap_i", {12'h0, i_o}, 32'h40000);
            check("gap_q", {12'h0, q_o}, 32'h0);
            check("gap_valid", {31'h0, out_valid_o}, 32'h1);
        end

        // Random samples and gaps against the reference model
        begin
            int got = 0;
            int dumps = 0;
            int cyc = 0;
            bit en, vld;
            logic [19:0] s;
            do_reset();
            while (dumps < 4 && cyc < 4000) begin
                en  = ($urandom_range(0, 4) != 0);
                vld = ($urandom_range(0, 4) != 0);
                s   = 20'($urandom);
                if ($urandom_range(0, 7) == 0) s = ($urandom_range(0, 1) != 0) ? 20'h7FFFF : 20'h80000;
                feed(s, en, vld, 1'b1);
                if (en && vld) begin
                    dump_buf[got] = s;
                    got++;
                    if (got == N) begin
                        check("rnd_valid", {31'h0, out_valid_o}, 32'h1);
                        check("rnd_i", {12'h0, i_o}, {12'h0, model(1'b0)});
                        check("rnd_q", {12'h0, q_o}, {12'h0, model(1'b1)});
                        got = 0;
                        dumps++;
                    end
                end
                cyc++;
            end
            check("rnd_dumps", dumps, 4);
            check("rnd_overrun", {31'h0, overrun_o}, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
